// File: rtl/ram_arb_pkg.sv
// Shared types for ram_arbiter: FSM states, owner encoding, read-tag payload
// and burst/statistics counter widths.
package ram_arb_pkg;

  localparam int unsigned BC_W      = 4;
  localparam int unsigned GNT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // Burst counter increment that sticks at the configured ceiling.
  function automatic logic [BC_W-1:0] bc_step(input logic [BC_W-1:0] bc,
                                              input logic [BC_W-1:0] max_bc);
    return (bc < max_bc) ? BC_W'(bc + BC_W'(1)) : max_bc;
  endfunction

endpackage

// File: rtl/ram_arb_rd_tag_pipe.sv
// Read-tag tracker: RD_LAT-deep shift register of {valid, owner} that marks
// which requester the RAM read data belongs to when it emerges.
module ram_arb_rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    issue_valid,
  input  owner_e  issue_owner,
  output rd_tag_t tag_out
);

  rd_tag_t [RD_LAT-1:0] pipe_q;
  rd_tag_t [RD_LAT-1:0] pipe_d;

  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].valid = issue_valid;
    pipe_d[0].owner = issue_owner;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter with bounded bursts and tie-break on
// last-served side. Optional grant statistics when RAM_ARB_STATS_EN is defined.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [GNT_CNT_W-1:0] a_gnt_cnt,
  output logic [GNT_CNT_W-1:0] b_gnt_cnt
`endif
);

  localparam logic [BC_W-1:0] MAX_BC = BC_W'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              gnt_a, gnt_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              wr_en_c, rd_issue_c;
  rd_tag_t           tag;

  // Grant decision and next state; reset suppresses any grant this cycle.
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    last_d  = last_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (a_req && (!b_req || last_q == OWNER_B)) gnt_a = 1'b1;
          else if (b_req)                             gnt_b = 1'b1;
        end
        OWN_A: begin
          if (a_req && (bc_q < MAX_BC || !b_req)) gnt_a = 1'b1;
          else if (b_req)                         gnt_b = 1'b1;
        end
        OWN_B: begin
          if (b_req && (bc_q < MAX_BC || !a_req)) gnt_b = 1'b1;
          else if (a_req)                         gnt_a = 1'b1;
        end
        default: ;
      endcase
    end
    if (gnt_a) begin
      state_d = OWN_A;
      last_d  = OWNER_A;
      bc_d    = (state_q == OWN_A) ? bc_step(bc_q, MAX_BC) : BC_W'(1);
    end else if (gnt_b) begin
      state_d = OWN_B;
      last_d  = OWNER_B;
      bc_d    = (state_q == OWN_B) ? bc_step(bc_q, MAX_BC) : BC_W'(1);
    end else begin
      state_d = IDLE;
      bc_d    = '0;
    end
  end

  // Route the granted request onto the RAM ports; addresses hold otherwise.
  always_comb begin
    sel_we     = gnt_b ? b_we    : a_we;
    sel_addr   = gnt_b ? b_addr  : a_addr;
    sel_wdata  = gnt_b ? b_wdata : a_wdata;
    wr_en_c    = (gnt_a | gnt_b) & sel_we;
    rd_issue_c = (gnt_a | gnt_b) & ~sel_we;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    if (wr_en_c) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_wdata;
    end
    if (rd_issue_c) rd_addr_d = sel_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bc_q      <= '0;
      last_q    <= OWNER_B;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      bc_q      <= bc_d;
      last_q    <= last_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  ram_arb_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (rd_issue_c),
    .issue_owner (gnt_b ? OWNER_B : OWNER_A),
    .tag_out     (tag)
  );

  assign a_gnt       = gnt_a;
  assign b_gnt       = gnt_b;
  assign ram_wr_en   = wr_en_c;
  assign ram_wr_addr = wr_addr_d;
  assign ram_wr_data = wr_data_d;
  assign ram_rd_addr = rd_addr_d;
  assign a_rdata     = ram_rd_data;
  assign b_rdata     = ram_rd_data;
  // A read landing in a reset cycle belongs to a discarded transaction.
  assign a_rvalid    = ~rst & tag.valid & (tag.owner == OWNER_A);
  assign b_rvalid    = ~rst & tag.valid & (tag.owner == OWNER_B);

`ifdef RAM_ARB_STATS_EN
  logic [GNT_CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [GNT_CNT_W-1:0] b_cnt_q, b_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (gnt_a && a_cnt_q != '1) a_cnt_d = a_cnt_q + GNT_CNT_W'(1);
    if (gnt_b && b_cnt_q != '1) b_cnt_d = b_cnt_q + GNT_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_gnt_cnt = a_cnt_q;
  assign b_gnt_cnt = b_cnt_q;
`endif

endmodule
